// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite subordinate backed by a bank of NUM_REGS 32-bit registers.
// Define AXIL_SLV_ADDR_CHECK_EN to reject addresses above the index range.
module axi4_lite_slave_regfile #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDRESS-1:0]      S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ADDRESS-1:0]      S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SW = DATA_WIDTH / 8;

    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDRESS-1:0]    aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;
    logic [IW-1:0]         aw_idx, ar_idx;
    logic                  aw_oor, ar_oor;
    logic                  unused_addr_bits;

    // READYs are held low while reset is asserted
    assign S_AWREADY = ARESETN && !aw_held_q && !bvalid_q;
    assign S_WREADY  = ARESETN && !w_held_q && !bvalid_q;
    assign S_ARREADY = ARESETN && !rvalid_q;

    assign aw_hs = S_AWVALID && S_AWREADY;
    assign w_hs  = S_WVALID && S_WREADY;
    assign ar_hs = S_ARVALID && S_ARREADY;

    // a held beat wins over the live bus; the live bus is only used on handshake
    assign aw_addr = aw_held_q ? awaddr_q : S_AWADDR;
    assign w_data  = w_held_q ? wdata_q : S_WDATA;
    assign w_strb  = w_held_q ? wstrb_q : S_WSTRB;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign aw_idx = aw_addr[IW+1:2];
    assign ar_idx = S_ARADDR[IW+1:2];

`ifdef AXIL_SLV_ADDR_CHECK_EN
    assign aw_oor = |aw_addr[ADDRESS-1:IW+2];
    assign ar_oor = |S_ARADDR[ADDRESS-1:IW+2];
    assign unused_addr_bits = ^{aw_addr[1:0], S_ARADDR[1:0]};
`else
    // upper bits are ignored, so the index aliases across the address space
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
    assign unused_addr_bits = ^{aw_addr[ADDRESS-1:IW+2], aw_addr[1:0],
                                S_ARADDR[ADDRESS-1:IW+2], S_ARADDR[1:0]};
`endif

    // write path: capture AW/W independently, commit once both are present
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        if (bvalid_q && S_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_oor ? 2'b10 : 2'b00;
            if (!aw_oor) begin
                for (int b = 0; b < SW; b++) begin
                    if (w_strb[b]) begin
                        regs_d[aw_idx][8*b +: 8] = w_data[8*b +: 8];
                    end
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = S_AWADDR;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_WDATA;
                wstrb_d  = S_WSTRB;
            end
        end
    end

    // read path: the register array is sampled before any same-edge write
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_oor ? 2'b10 : 2'b00;
            rdata_d  = ar_oor ? 32'hDEAD_BEEF : regs_q[ar_idx];
        end else if (rvalid_q && S_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // state update with asynchronous clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            regs_q    <= '{default: '0};
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign S_BVALID = bvalid_q;
    assign S_BRESP  = bresp_q;
    assign S_RVALID = rvalid_q;
    assign S_RRESP  = rresp_q;
    assign S_RDATA  = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Randomized bench for axi4_lite_slave_regfile against an array model.
// Honors AXIL_SLV_ADDR_CHECK_EN the same way the design does.
module tb_axi4_lite_slave_regfile;

    localparam int NR = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] S_AWADDR = '0;
    logic        S_AWVALID = 1'b0;
    logic        S_AWREADY;
    logic [31:0] S_WDATA = '0;
    logic [3:0]  S_WSTRB = '0;
    logic        S_WVALID = 1'b0;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY = 1'b0;
    logic [31:0] S_ARADDR = '0;
    logic        S_ARVALID = 1'b0;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] mdl [NR];

    axi4_lite_slave_regfile #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID),
        .S_RREADY(S_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit is_oor(input logic [31:0] a);
`ifdef AXIL_SLV_ADDR_CHECK_EN
        return (a / (NR * 4)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % NR);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return is_oor(a) ? 32'hDEAD_BEEF : mdl[idx_of(a)];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return is_oor(a) ? 2'b10 : 2'b00;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        if (!is_oor(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx_of(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead,
                            input int bdly);
        int aw_at, w_at, last;
        aw_at = (lead > 0) ? lead : 0;
        w_at  = (lead < 0) ? -lead : 0;
        last  = (aw_at > w_at) ? aw_at : w_at;
        for (int c = 0; c <= last; c++) begin
            @(negedge ACLK);
            S_AWVALID = (c == aw_at);
            S_AWADDR  = a;
            S_WVALID  = (c == w_at);
            S_WDATA   = d;
            S_WSTRB   = s;
            #1;
            if (c == aw_at) check("awready", S_AWREADY, 1);
            else if (c > aw_at) check("awready_held", S_AWREADY, 0);
            if (c == w_at) check("wready", S_WREADY, 1);
            else if (c > w_at) check("wready_held", S_WREADY, 0);
            check("bvalid_early", S_BVALID, 0);
        end
        @(negedge ACLK);
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        #1;
        check("bvalid", S_BVALID, 1);
        check("bresp", S_BRESP, exp_resp(a));
        mdl_write(a, d, s);
        for (int i = 0; i < bdly; i++) begin
            @(negedge ACLK);
            #1;
            check("bvalid_hold", S_BVALID, 1);
            check("bresp_hold", S_BRESP, exp_resp(a));
            check("awready_bstall", S_AWREADY, 0);
            check("wready_bstall", S_WREADY, 0);
        end
        S_BREADY = 1'b1;
        @(negedge ACLK);
        S_BREADY = 1'b0;
        #1;
        check("bvalid_clear", S_BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly);
        logic [31:0] e;
        e = exp_rd(a);
        @(negedge ACLK);
        S_ARVALID = 1'b1;
        S_ARADDR  = a;
        #1;
        check("arready", S_ARREADY, 1);
        @(negedge ACLK);
        S_ARVALID = 1'b0;
        #1;
        check("rvalid", S_RVALID, 1);
        check("rdata", S_RDATA, e);
        check("rresp", S_RRESP, exp_resp(a));
        for (int i = 0; i < rdly; i++) begin
            @(negedge ACLK);
            #1;
            check("rvalid_hold", S_RVALID, 1);
            check("rdata_hold", S_RDATA, e);
            check("arready_rstall", S_ARREADY, 0);
        end
        S_RREADY = 1'b1;
        @(negedge ACLK);
        S_RREADY = 1'b0;
        #1;
        check("rvalid_clear", S_RVALID, 0);
        check("arready_back", S_ARREADY, 1);
    endtask

    initial begin
        logic [31:0] a, d, old;
        mdl_reset();

        // reset state
        repeat (2) @(negedge ACLK);
        #1;
        check("rst_awready", S_AWREADY, 0);
        check("rst_wready", S_WREADY, 0);
        check("rst_arready", S_ARREADY, 0);
        check("rst_bvalid", S_BVALID, 0);
        check("rst_rvalid", S_RVALID, 0);
        check("rst_bresp", S_BRESP, 0);
        check("rst_rresp", S_RRESP, 0);
        check("rst_rdata", S_RDATA, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("post_awready", S_AWREADY, 1);
        check("post_wready", S_WREADY, 1);
        check("post_arready", S_ARREADY, 1);

        // directed cases
        do_write(32'h4, 32'hA5A5_1234, 4'hF, 0, 0);
        do_read(32'h4, 0);
        do_write(32'h8, 32'hFFFF_FFFF, 4'hF, 3, 0);
        do_read(32'h8, 0);
        do_write(32'h8, 32'h1122_3344, 4'b0101, 0, 0);
        do_read(32'h8, 0);
        check("strobe_model", mdl[2], 32'hFF22_FF44);
        do_write(32'hC, 32'h0BAD_F00D, 4'hF, -2, 5);
        do_read(32'hC, 5);
        do_write(32'h0000_1000, 32'h7777_7777, 4'hF, 0, 0);
        do_read(32'h0000_1000, 0);
        do_read(32'h0, 0);

        // same-edge read and write of one register returns the old value
        old = mdl[3];
        @(negedge ACLK);
        S_AWVALID = 1'b1; S_AWADDR = 32'hC;
        S_WVALID = 1'b1; S_WDATA = 32'h5555_AAAA; S_WSTRB = 4'hF;
        S_ARVALID = 1'b1; S_ARADDR = 32'hC;
        @(negedge ACLK);
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        #1;
        check("raw_rdata", S_RDATA, old);
        check("raw_bvalid", S_BVALID, 1);
        mdl_write(32'hC, 32'h5555_AAAA, 4'hF);
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        @(negedge ACLK);
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        do_read(32'hC, 0);

        // back-to-back reads with RREADY held high
        @(negedge ACLK);
        S_RREADY = 1'b1; S_ARVALID = 1'b1; S_ARADDR = 32'h4;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("b2b_arready", S_ARREADY, (c % 2 == 0) ? 1 : 0);
            check("b2b_rvalid", S_RVALID, (c % 2 == 1) ? 1 : 0);
            if (c % 2 == 1) check("b2b_rdata", S_RDATA, mdl[1]);
            if (c == 3) S_ARVALID = 1'b0;
            @(negedge ACLK);
        end
        S_RREADY = 1'b0;
        #1;
        check("b2b_rvalid_end", S_RVALID, 0);

        // reset after AW is held but before W arrives
        @(negedge ACLK);
        S_AWVALID = 1'b1; S_AWADDR = 32'h14;
        #1;
        check("mid_awready", S_AWREADY, 1);
        @(negedge ACLK);
        S_AWVALID = 1'b0;
        #1;
        ARESETN = 1'b0;
        #1;
        check("mid_rst_awready", S_AWREADY, 0);
        check("mid_rst_wready", S_WREADY, 0);
        check("mid_rst_arready", S_ARREADY, 0);
        mdl_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("mid_post_awready", S_AWREADY, 1);
        check("mid_post_wready", S_WREADY, 1);
        check("mid_post_arready", S_ARREADY, 1);
        check("mid_post_bvalid", S_BVALID, 0);
        @(negedge ACLK);
        S_WVALID = 1'b1; S_WDATA = 32'hCAFE_0001; S_WSTRB = 4'hF;
        @(negedge ACLK);
        S_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mid_w_only_bvalid", S_BVALID, 0);
            check("mid_w_only_awready", S_AWREADY, 1);
            @(negedge ACLK);
        end
        S_AWVALID = 1'b1; S_AWADDR = 32'h18;
        @(negedge ACLK);
        S_AWVALID = 1'b0;
        #1;
        check("mid_commit_bvalid", S_BVALID, 1);
        mdl_write(32'h18, 32'hCAFE_0001, 4'hF);
        S_BREADY = 1'b1;
        @(negedge ACLK);
        S_BREADY = 1'b0;
        do_read(32'h14, 0);
        do_read(32'h18, 0);
        do_read(32'h4, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            a = {26'd0, 4'($urandom_range(0, NR - 1)), 2'($urandom)};
            if ($urandom_range(0, 5) == 0) a[13:12] = 2'($urandom_range(1, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, d, 4'($urandom), $urandom_range(0, 6) - 3,
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite subordinate that terminates all five channels and backs them with a bank of 32-bit read/write registers. It is the responder end for the team's AXI4-Lite master on the same bus: it accepts write address/data, applies byte strobes and returns a write response, and answers read addresses with registered read data. It sits at the leaf of the control path and provides the software-visible register bank for FPGA bring-up and loopback tests.

## Interface
- ADDRESS, 32, width of S_AWADDR / S_ARADDR
- DATA_WIDTH, 32, data width; fixed at 32 (4 strobe bits)
- NUM_REGS, 16, number of 32-bit registers, 2..256, power of two
- ACLK  input  1  sole clock, rising edge
- ARESETN  input  1  asynchronous, active-low reset
- S_AWADDR  input  ADDRESS  write address
- S_AWVALID  input  1  write address valid
- S_AWREADY  output  1  write address ready
- S_WDATA  input  32  write data
- S_WSTRB  input  4  byte strobes, bit n enables byte n
- S_WVALID  input  1  write data valid
- S_WREADY  output  1  write data ready
- S_BRESP  output  2  write response (00 OKAY, 10 SLVERR)
- S_BVALID  output  1  write response valid
- S_BREADY  input  1  write response ready
- S_ARADDR  input  ADDRESS  read address
- S_ARVALID  input  1  read address valid
- S_ARREADY  output  1  read address ready
- S_RDATA  output  32  read data
- S_RRESP  output  2  read response
- S_RVALID  output  1  read data valid
- S_RREADY  input  1  read data ready

## Operation
- Register index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored. All registers reset to 32'h0.
- Write path: internal flags aw_held, w_held with captured address/data/strobe. S_AWREADY = !aw_held && !S_BVALID; S_WREADY = !w_held && !S_BVALID. AW and W accepted independently, in either order or same cycle.
- Commit: on the edge where address and data are both available (held or handshaking that cycle), update bytes with strobe=1, clear both flags, set S_BVALID=1 with S_BRESP. S_BVALID holds until S_BREADY; no new AW/W accepted while S_BVALID=1.
- Read path: S_ARREADY = !S_RVALID. On AR handshake, capture register value into S_RDATA, set S_RRESP, S_RVALID=1 next edge; hold stable until S_RREADY.
- Read and write to same register committing on the same edge: read returns pre-write value.
- Read and write channels fully independent; no priority.

## Timing
- ARESETN low (asynchronous): S_BVALID=0, S_RVALID=0, S_BRESP=00, S_RRESP=00, S_RDATA=0, flags cleared, registers 0; S_AWREADY/S_WREADY/S_ARREADY forced 0 while ARESETN low, 1 from the first cycle after deassertion.
- Reset mid-transaction: in-flight AW/W/AR discarded, no response issued, partially captured write not applied.
- Write latency: AW and W handshake in cycle N -> S_BVALID=1 in cycle N+1. AW in N, W in N+k -> S_BVALID in N+k+1.
- Read latency: AR handshake cycle N -> S_RVALID=1 in cycle N+1. Back-to-back reads: one accepted every 2 cycles when S_RREADY held high (ARREADY drops while RVALID=1).
- S_BVALID and S_RVALID never deassert without the matching READY (AXI rule).

## Configuration
- AXIL_SLV_ADDR_CHECK_EN defined: address with any bit above index range set (addr[ADDRESS-1:log2(NUM_REGS)+2] != 0) is out of range; write dropped with S_BRESP=10, read returns S_RDATA=32'hDEAD_BEEF with S_RRESP=10.
- Not defined: upper address bits ignored (index aliases/wraps), all responses 00 OKAY.

## Test plan
- Reset then write 0x0000_0004 <- 0xA5A5_1234, strobe 1111, AW+W same cycle -> S_BVALID next cycle, BRESP=00; read 0x4 -> RDATA=0xA5A5_1234, RRESP=00, RVALID 1 cycle after AR.
- W sent 3 cycles before AW (addr 0x8, data 0xFFFF_FFFF) -> WREADY drops after W accept, BVALID 1 cycle after AW handshake; read 0x8 = 0xFFFF_FFFF.
- Strobe 0101 write 0x1122_3344 over 0xFFFF_FFFF at 0x8 -> read returns 0xFF22_FF44.
- BREADY held low 5 cycles -> BVALID, BRESP stable, AWREADY/WREADY=0 throughout; RREADY low likewise keeps RDATA stable and ARREADY=0.
- With AXIL_SLV_ADDR_CHECK_EN: write/read 0x0000_1000 -> BRESP=10, RRESP=10, RDATA=0xDEAD_BEEF, register 0 unchanged; without it, same access hits register 0 with OKAY.
- Assert ARESETN low after AW accepted but before W -> after reset no BVALID, registers 0, all READYs 1.
